// File: rtl/bus_invert_decoder.sv
// ---------------------------------------------------------------------------
// bus_invert_decoder
//   Receive side of a bus-invert link. Restores the original data word from
//   the encoded lines plus the invert line, forwards it through a one-stage
//   registered valid/ready pipeline, checks every accepted word against the
//   bus-invert policy, and keeps saturating statistics for measurements of
//   switched capacitance.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   bus_in, inv_in  : encoded data lines and invert line as received
//   in_valid        : a word is presented on bus_in/inv_in
//   in_ready        : decoder can take a word (combinational)
//   data_out        : decoded word (registered)
//   out_valid       : data_out holds a valid word
//   out_ready       : downstream takes data_out this cycle
//   policy_err      : sticky flag, some accepted word broke the invert policy
//   clr_stats       : synchronous clear of counters and policy_err
//   word_cnt, inv_cnt, err_cnt, toggle_cnt : saturating statistics
// ---------------------------------------------------------------------------
module bus_invert_decoder #(
  parameter int WIDTH  = 8,
  parameter int THRESH = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             inv_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             policy_err,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] inv_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] toggle_cnt
);

  // Hamming distance of a WIDTH-bit word needs clog2(WIDTH+1) bits; the
  // toggle count adds the invert line on top, so it may need one more.
  localparam int HW = $clog2(WIDTH + 1);
  localparam int TW = $clog2(WIDTH + 2);
  localparam int SW = CNT_W + 1;

  function automatic logic [HW-1:0] f_popcount(input logic [WIDTH-1:0] v);
    logic [HW-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + HW'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : (c + CNT_W'(1));
  endfunction

  // Add with a carry bit so an overflow clamps to all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] f_sat_add(input logic [CNT_W-1:0] c,
                                                 input logic [TW-1:0]    a);
    logic [SW-1:0] s;
    s = {1'b0, c} + SW'(a);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  logic [WIDTH-1:0] r_data_out;
  logic             r_out_valid;
  logic             r_policy_err;
  logic [CNT_W-1:0] r_word_cnt;
  logic [CNT_W-1:0] r_inv_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_toggle_cnt;
  logic [WIDTH-1:0] r_prev_data;
  logic [WIDTH-1:0] r_prev_bus;
  logic             r_prev_inv;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_xfer;
  logic [WIDTH-1:0] w_dec;
  logic [HW-1:0]    w_hd;
  logic             w_viol;
  logic [TW-1:0]    w_tg;

  assign w_in_ready = !r_out_valid || out_ready;
  assign w_accept   = in_valid && w_in_ready;
  assign w_xfer     = r_out_valid && out_ready;
  assign w_dec      = inv_in ? ~bus_in : bus_in;
  assign w_hd       = f_popcount(w_dec ^ r_prev_data);
  // The encoder inverts strictly above THRESH, so HD == THRESH with the
  // invert line set counts as a violation.
  assign w_viol     = ((int'(w_hd) > THRESH) != inv_in);
  assign w_tg       = TW'(f_popcount(bus_in ^ r_prev_bus)) + TW'(inv_in ^ r_prev_inv);

  // Output stage: load on accept, drop valid on a transfer without refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_data_out  <= w_dec;
      r_out_valid <= 1'b1;
    end else if (w_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

  // History of the last accepted word, used by the policy and toggle checks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_data <= '0;
      r_prev_bus  <= '0;
      r_prev_inv  <= 1'b0;
    end else if (w_accept) begin
      r_prev_data <= w_dec;
      r_prev_bus  <= bus_in;
      r_prev_inv  <= inv_in;
    end
  end

  // Statistics; a clear in the same cycle as an accept discards that word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_policy_err <= 1'b0;
      r_word_cnt   <= '0;
      r_inv_cnt    <= '0;
      r_err_cnt    <= '0;
      r_toggle_cnt <= '0;
    end else if (clr_stats) begin
      r_policy_err <= 1'b0;
      r_word_cnt   <= '0;
      r_inv_cnt    <= '0;
      r_err_cnt    <= '0;
      r_toggle_cnt <= '0;
    end else if (w_accept) begin
      r_word_cnt   <= f_sat_inc(r_word_cnt);
      r_toggle_cnt <= f_sat_add(r_toggle_cnt, w_tg);
      if (inv_in) begin
        r_inv_cnt <= f_sat_inc(r_inv_cnt);
      end
      if (w_viol) begin
        r_err_cnt    <= f_sat_inc(r_err_cnt);
        r_policy_err <= 1'b1;
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign data_out   = r_data_out;
  assign out_valid  = r_out_valid;
  assign policy_err = r_policy_err;
  assign word_cnt   = r_word_cnt;
  assign inv_cnt    = r_inv_cnt;
  assign err_cnt    = r_err_cnt;
  assign toggle_cnt = r_toggle_cnt;

endmodule

// File: tb/tb_bus_invert_decoder.sv
module tb_bus_invert_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  bus_in = 8'h00;
  logic        inv_in = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        clr_stats = 1'b0;

  logic        in_ready, out_valid, policy_err;
  logic [7:0]  data_out;
  logic [15:0] word_cnt, inv_cnt, err_cnt, toggle_cnt;

  logic        s_in_ready, s_out_valid, s_policy_err;
  logic [7:0]  s_data_out;
  logic [3:0]  s_word_cnt, s_inv_cnt, s_err_cnt, s_toggle_cnt;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  bus_invert_decoder #(.WIDTH(8), .THRESH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus_in(bus_in), .inv_in(inv_in), .in_valid(in_valid),
    .in_ready(in_ready), .data_out(data_out), .out_valid(out_valid),
    .out_ready(out_ready), .policy_err(policy_err), .clr_stats(clr_stats),
    .word_cnt(word_cnt), .inv_cnt(inv_cnt), .err_cnt(err_cnt), .toggle_cnt(toggle_cnt)
  );

  bus_invert_decoder #(.WIDTH(8), .THRESH(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .bus_in(bus_in), .inv_in(inv_in), .in_valid(in_valid),
    .in_ready(s_in_ready), .data_out(s_data_out), .out_valid(s_out_valid),
    .out_ready(out_ready), .policy_err(s_policy_err), .clr_stats(clr_stats),
    .word_cnt(s_word_cnt), .inv_cnt(s_inv_cnt), .err_cnt(s_err_cnt), .toggle_cnt(s_toggle_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    compared++; if (data_out !== 8'h00) begin mismatched++; $display("FAIL reset_data_out got %h want 00", data_out); end
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    compared++; if ({policy_err, word_cnt, inv_cnt, err_cnt, toggle_cnt} !== 65'd0) begin
      mismatched++; $display("FAIL reset_stats got %b/%h/%h/%h/%h want all 0", policy_err, word_cnt, inv_cnt, err_cnt, toggle_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_decode();
    in_valid = 1'b1; bus_in = 8'h0F; inv_in = 1'b0; out_ready = 1'b1;
    tick();
    compared++; if (data_out !== 8'h0F || out_valid !== 1'b1) begin mismatched++; $display("FAIL plain_word got %h/%b want 0f/1", data_out, out_valid); end
    compared++; if (word_cnt !== 16'd1 || toggle_cnt !== 16'd4 || err_cnt !== 16'd0) begin
      mismatched++; $display("FAIL plain_stats got w=%0d t=%0d e=%0d want 1/4/0", word_cnt, toggle_cnt, err_cnt);
    end
    inv_in = 1'b1;
    tick();
    compared++; if (data_out !== 8'hF0) begin mismatched++; $display("FAIL inverted_word got %h want f0", data_out); end
    compared++; if (inv_cnt !== 16'd1 || toggle_cnt !== 16'd5 || err_cnt !== 16'd0 || word_cnt !== 16'd2) begin
      mismatched++; $display("FAIL inverted_stats got i=%0d t=%0d e=%0d w=%0d want 1/5/0/2", inv_cnt, toggle_cnt, err_cnt, word_cnt);
    end
    in_valid = 1'b0;
    tick();
    compared++; if (out_valid !== 1'b0 || data_out !== 8'hF0) begin mismatched++; $display("FAIL drain got %b/%h want 0/f0", out_valid, data_out); end
  endtask

  task automatic test_policy();
    rst = 1'b1; #1; rst = 1'b0;
    in_valid = 1'b1; bus_in = 8'h1F; inv_in = 1'b0;
    tick();
    compared++; if (err_cnt !== 16'd1 || policy_err !== 1'b1) begin mismatched++; $display("FAIL missed_invert got e=%0d p=%b want 1/1", err_cnt, policy_err); end
    compared++; if (toggle_cnt !== 16'd5) begin mismatched++; $display("FAIL missed_invert_toggle got %0d want 5", toggle_cnt); end
    bus_in = 8'h1E;  // hd 1 from 0x1F, legal
    tick();
    compared++; if (policy_err !== 1'b1 || err_cnt !== 16'd1) begin mismatched++; $display("FAIL sticky got p=%b e=%0d want 1/1", policy_err, err_cnt); end
    bus_in = 8'hEE; inv_in = 1'b1;  // dec 0x11, hd exactly 4 with invert set
    tick();
    compared++; if (data_out !== 8'h11 || err_cnt !== 16'd2) begin mismatched++; $display("FAIL hd_eq_thresh got d=%h e=%0d want 11/2", data_out, err_cnt); end
    in_valid = 1'b0; clr_stats = 1'b1;
    tick();
    compared++; if ({policy_err, word_cnt, inv_cnt, err_cnt, toggle_cnt} !== 65'd0 || data_out !== 8'h11) begin
      mismatched++; $display("FAIL clear got p=%b w=%0d e=%0d d=%h want 0/0/0/11", policy_err, word_cnt, err_cnt, data_out);
    end
    in_valid = 1'b1; bus_in = 8'h00; inv_in = 1'b0;  // clear and accept together
    tick();
    compared++; if (word_cnt !== 16'd0 || toggle_cnt !== 16'd0 || data_out !== 8'h00 || out_valid !== 1'b1) begin
      mismatched++; $display("FAIL clear_wins got w=%0d t=%0d d=%h v=%b want 0/0/00/1", word_cnt, toggle_cnt, data_out, out_valid);
    end
    clr_stats = 1'b0; in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; bus_in = 8'h01; inv_in = 1'b0;
    tick();
    compared++; if (data_out !== 8'h01 || word_cnt !== 16'd1 || toggle_cnt !== 16'd1) begin
      mismatched++; $display("FAIL bp_load got d=%h w=%0d t=%0d want 01/1/1", data_out, word_cnt, toggle_cnt);
    end
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
    bus_in = 8'h03;
    tick();
    tick();
    compared++; if (data_out !== 8'h01 || out_valid !== 1'b1 || word_cnt !== 16'd1 || toggle_cnt !== 16'd1) begin
      mismatched++; $display("FAIL bp_hold got d=%h v=%b w=%0d t=%0d want 01/1/1/1", data_out, out_valid, word_cnt, toggle_cnt);
    end
    out_ready = 1'b1;
    #1;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    tick();
    compared++; if (data_out !== 8'h03 || word_cnt !== 16'd2 || toggle_cnt !== 16'd2 || err_cnt !== 16'd0) begin
      mismatched++; $display("FAIL bp_release got d=%h w=%0d t=%0d e=%0d want 03/2/2/0", data_out, word_cnt, toggle_cnt, err_cnt);
    end
  endtask

  task automatic test_streaming();
    logic [7:0] exp_d;
    rst = 1'b1; #1; rst = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; inv_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_d = (i % 2 == 0) ? 8'h00 : 8'hFF;
      bus_in = exp_d;
      tick();
      compared++; if (data_out !== exp_d || out_valid !== 1'b1) begin
        mismatched++; $display("FAIL stream_word%0d got %h/%b want %h/1", i, data_out, out_valid, exp_d);
      end
    end
    // Word 0 is 0x00 against history 0; words 1..9 each flip all 8 lines
    // without inverting, so each is a policy error.
    compared++; if (word_cnt !== 16'd10 || err_cnt !== 16'd9 || toggle_cnt !== 16'd72 || inv_cnt !== 16'd0) begin
      mismatched++; $display("FAIL stream_stats got w=%0d e=%0d t=%0d i=%0d want 10/9/72/0", word_cnt, err_cnt, toggle_cnt, inv_cnt);
    end
    compared++; if (s_word_cnt !== 4'd10 || s_err_cnt !== 4'd9 || s_toggle_cnt !== 4'd15) begin
      mismatched++; $display("FAIL stream_narrow got w=%0d e=%0d t=%0d want 10/9/15", s_word_cnt, s_err_cnt, s_toggle_cnt);
    end
  endtask

  task automatic test_saturation_reset();
    rst = 1'b1; #1; rst = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; inv_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus_in = (i % 2 == 0) ? 8'h00 : 8'hFF;
      tick();
    end
    compared++; if (s_word_cnt !== 4'd15 || s_err_cnt !== 4'd15 || s_toggle_cnt !== 4'd15 || s_inv_cnt !== 4'd0) begin
      mismatched++; $display("FAIL saturate got w=%0d e=%0d t=%0d i=%0d want 15/15/15/0", s_word_cnt, s_err_cnt, s_toggle_cnt, s_inv_cnt);
    end
    compared++; if (word_cnt !== 16'd20 || err_cnt !== 16'd19 || toggle_cnt !== 16'd152) begin
      mismatched++; $display("FAIL wide_counts got w=%0d e=%0d t=%0d want 20/19/152", word_cnt, err_cnt, toggle_cnt);
    end
    #3; rst = 1'b1; #1;
    compared++; if (out_valid !== 1'b0 || s_out_valid !== 1'b0 || word_cnt !== 16'd0 || toggle_cnt !== 16'd0 || err_cnt !== 16'd0
                    || s_word_cnt !== 4'd0 || policy_err !== 1'b0) begin
      mismatched++; $display("FAIL async_reset got v=%b sv=%b w=%0d t=%0d e=%0d sw=%0d p=%b want all 0",
                             out_valid, s_out_valid, word_cnt, toggle_cnt, err_cnt, s_word_cnt, policy_err);
    end
    rst = 1'b0;
    bus_in = 8'h1F; inv_in = 1'b0;
    tick();
    compared++; if (data_out !== 8'h1F || err_cnt !== 16'd1 || toggle_cnt !== 16'd5 || word_cnt !== 16'd1) begin
      mismatched++; $display("FAIL post_reset_history got d=%h e=%0d t=%0d w=%0d want 1f/1/5/1", data_out, err_cnt, toggle_cnt, word_cnt);
    end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_policy();
    test_backpressure();
    test_streaming();
    test_saturation_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
